// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: FSM states, requester IDs
// and the all-ones strobe used for instruction fetches.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef enum logic {
    FETCH = 1'b0,
    DATA  = 1'b1
  } req_id_e;

  // Wide enough for any sensible DW; the top slices off DW/8 bits.
  localparam logic [127:0] FETCH_STRB_ONES = '1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory-side signals of the arbiter.
// slave  : the arbiter's view.
// master : the environment's view (requesters + memory).
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic              i_req_valid;
  logic              i_req_ready;
  logic [AW-1:0]     i_addr;
  logic              i_rsp_valid;
  logic              i_rsp_err;
  logic [DW-1:0]     i_rdata;

  logic              d_req_valid;
  logic              d_req_ready;
  logic              d_we;
  logic [AW-1:0]     d_addr;
  logic [DW-1:0]     d_wdata;
  logic [DW/8-1:0]   d_wstrb;
  logic              d_rsp_valid;
  logic              d_rsp_err;
  logic [DW-1:0]     d_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic [DW/8-1:0]   mem_wstrb;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DW-1:0]     mem_rdata;

  modport slave (
    input  i_req_valid, i_addr,
    output i_req_ready, i_rsp_valid, i_rsp_err, i_rdata,
    input  d_req_valid, d_we, d_addr, d_wdata, d_wstrb,
    output d_req_ready, d_rsp_valid, d_rsp_err, d_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport master (
    output i_req_valid, i_addr,
    input  i_req_ready, i_rsp_valid, i_rsp_err, i_rdata,
    output d_req_valid, d_we, d_addr, d_wdata, d_wstrb,
    input  d_req_ready, d_rsp_valid, d_rsp_err, d_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/mem_arb_select.sv
// Requester selection for the memory port arbiter.
// Default: data has priority, but after MAX_DATA_STREAK consecutive data
// grants with fetch waiting, fetch wins the next tie.
// With MEM_ARB_ROUND_ROBIN_EN defined: ties go to whoever was not granted
// last (data wins the first tie after reset).
module mem_arb_select
  import mem_arb_pkg::*;
#(
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    i_valid,
  input  logic    d_valid,
  input  logic    grant_en,
  output req_id_e winner
);

`ifdef MEM_ARB_ROUND_ROBIN_EN

  req_id_e last_grant;

  // Alternate on ties, otherwise pick whoever is asking.
  always_comb begin
    winner = FETCH;
    if (i_valid && d_valid) winner = (last_grant == FETCH) ? DATA : FETCH;
    else if (d_valid)       winner = DATA;
  end

  // Remember who was granted last.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               last_grant <= FETCH;
    else if (grant_en && (i_valid || d_valid)) last_grant <= winner;
  end

`else

  localparam int SW = (MAX_DATA_STREAK > 0) ? $clog2(MAX_DATA_STREAK + 1) : 1;

  logic [SW-1:0] streak;
  logic          at_limit;

  assign at_limit = (streak == SW'(MAX_DATA_STREAK));

  // Data wins unless fetch has been waiting through a full data streak.
  always_comb begin
    winner = FETCH;
    if (d_valid && !(i_valid && at_limit)) winner = DATA;
  end

  // Count data grants that happen while fetch is waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           streak <= '0;
    else if (!i_valid) streak <= '0;
    else if (grant_en) streak <= (winner == DATA) ? streak + SW'(1) : '0;
  end

`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing one memory port between instruction
// fetch (read-only) and load/store (read/write). A lost response is turned
// into an error response after TIMEOUT wait cycles (0 = never).
// Build option: MEM_ARB_ROUND_ROBIN_EN selects round-robin tie-breaking
// instead of data priority with a fetch anti-starvation limit.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW              = 32,
  parameter int DW              = 32,
  parameter int MAX_DATA_STREAK = 4,
  parameter int TIMEOUT         = 64
) (
  input logic              clk,
  input logic              rst,
  mem_port_arbiter_if.slave bus
);

  localparam int SBW  = DW / 8;
  localparam int TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int TLIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  state_e        state;
  req_id_e       owner;
  req_id_e       winner;
  logic [TW-1:0] timer;
  logic          grant_en;
  logic          accept;
  logic          timed_out;
  logic          wait_done;
  logic [DW-1:0] rsp_data;

  // Requests are only taken while idle; reset also forces ready low.
  assign grant_en = !rst && (state == IDLE);

  mem_arb_select #(
    .MAX_DATA_STREAK(MAX_DATA_STREAK)
  ) u_select (
    .clk      (clk),
    .rst      (rst),
    .i_valid  (bus.i_req_valid),
    .d_valid  (bus.d_req_valid),
    .grant_en (grant_en),
    .winner   (winner)
  );

  assign bus.i_req_ready = grant_en && bus.i_req_valid && (winner == FETCH);
  assign bus.d_req_ready = grant_en && bus.d_req_valid && (winner == DATA);
  assign accept          = bus.i_req_ready || bus.d_req_ready;

  // Wait-phase completion: real response, or the timer ran out.
  always_comb begin
    timed_out = (TIMEOUT != 0) && (timer == TW'(TLIM));
    wait_done = bus.mem_rvalid || timed_out;
    rsp_data  = (bus.mem_rvalid && !bus.mem_we) ? bus.mem_rdata : '0;
  end

  // Transaction FSM; all memory-side and response outputs are registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      owner           <= FETCH;
      timer           <= '0;
      bus.mem_req     <= 1'b0;
      bus.mem_we      <= 1'b0;
      bus.mem_addr    <= '0;
      bus.mem_wdata   <= '0;
      bus.mem_wstrb   <= '0;
      bus.i_rsp_valid <= 1'b0;
      bus.i_rsp_err   <= 1'b0;
      bus.i_rdata     <= '0;
      bus.d_rsp_valid <= 1'b0;
      bus.d_rsp_err   <= 1'b0;
      bus.d_rdata     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            owner       <= winner;
            bus.mem_req <= 1'b1;
            if (winner == DATA) begin
              bus.mem_we    <= bus.d_we;
              bus.mem_addr  <= bus.d_addr;
              bus.mem_wdata <= bus.d_wdata;
              bus.mem_wstrb <= bus.d_wstrb;
            end else begin
              bus.mem_we    <= 1'b0;
              bus.mem_addr  <= bus.i_addr;
              bus.mem_wdata <= '0;
              bus.mem_wstrb <= FETCH_STRB_ONES[SBW-1:0];
            end
            state <= ISSUE;
          end
        end
        ISSUE: begin
          // Fields stay frozen until the memory takes the request.
          if (bus.mem_gnt) begin
            bus.mem_req <= 1'b0;
            timer       <= '0;
            state       <= WAIT;
          end
        end
        WAIT: begin
          if (wait_done) begin
            if (owner == FETCH) begin
              bus.i_rsp_valid <= 1'b1;
              bus.i_rsp_err   <= !bus.mem_rvalid;
              bus.i_rdata     <= rsp_data;
            end else begin
              bus.d_rsp_valid <= 1'b1;
              bus.d_rsp_err   <= !bus.mem_rvalid;
              bus.d_rdata     <= rsp_data;
            end
            state <= RESP;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        RESP: begin
          // One-cycle pulse; data/err registers keep their value.
          bus.i_rsp_valid <= 1'b0;
          bus.d_rsp_valid <= 1'b0;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the core's single-port instruction/data memory between the instruction-fetch requester (read-only) and the load/store requester (read/write).
- Sits between the PC/fetch logic and the load/store path on one side, and the memory on the other.
- Allows exactly one outstanding memory transaction.
- Fixed data priority with a fetch anti-starvation limit, and a timeout that converts a lost response into an error response.

Parameters:
AW, 32, address width
DW, 32, data width; strobe width is DW/8
MAX_DATA_STREAK, 4, consecutive data grants allowed while fetch is pending; minimum 1
TIMEOUT, 64, cycles to wait for mem_rvalid after mem_gnt; 0 disables the timeout

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
i_req_valid  in  1  fetch request valid
i_req_ready  out  1  fetch request accepted this cycle
i_addr  in  AW  fetch address
i_rsp_valid  out  1  fetch response, single-cycle pulse
i_rsp_err  out  1  fetch response is a timeout error
i_rdata  out  DW  fetch read data
d_req_valid  in  1  data request valid
d_req_ready  out  1  data request accepted this cycle
d_we  in  1  1 = write, 0 = read
d_addr  in  AW  data address
d_wdata  in  DW  write data
d_wstrb  in  DW/8  byte strobes
d_rsp_valid  out  1  data response, single-cycle pulse (write ack or read data)
d_rsp_err  out  1  data response is a timeout error
d_rdata  out  DW  data read data; 0 for writes
mem_req  out  1  memory request
mem_we  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_wstrb  out  DW/8  memory strobes; all-ones for fetch
mem_gnt  in  1  memory accepted mem_req
mem_rvalid  in  1  memory response valid
mem_rdata  in  DW  memory read data

Behaviour:
- Reset (async, rst=1):
  - state IDLE, streak=0, timer=0, owner=FETCH.
  - All valid/ready/req/err outputs 0; all data/address outputs 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - *_req_ready is combinational: 1 only for the selected requester, and only while in IDLE.
  - On valid&&ready: latch addr/we/wdata/wstrb and the owner; go to ISSUE.
  - No valid: stay in IDLE.
- Selection (macro absent):
  - Data wins a simultaneous request unless streak==MAX_DATA_STREAK, in which case fetch wins.
  - streak increments on a data grant while i_req_valid=1; clears on any fetch grant or when i_req_valid=0.
- ISSUE:
  - mem_req=1 with registered fields; mem_we=0 for fetch.
  - Hold until mem_gnt=1, then go to WAIT with timer=0.
  - Fields must stay stable while mem_req=1 and mem_gnt=0.
- WAIT:
  - mem_rvalid=1: capture mem_rdata (force 0 if write); go to RESP with err=0.
  - Otherwise the timer increments. If TIMEOUT!=0 and timer==TIMEOUT-1, go to RESP with err=1 and rdata=0.
  - mem_rvalid in the gnt cycle, or in any state other than WAIT, is ignored (this discards stale post-timeout responses).
- RESP:
  - Owner's rsp_valid=1 for exactly one cycle, with rdata/err registered.
  - No backpressure on responses. Return to IDLE.
- Latency/throughput:
  - Request acceptance to rsp_valid is at least 3 cycles (ISSUE, WAIT, RESP) with gnt and rvalid immediate.
  - Best-case throughput is one transaction per 4 cycles.
- Reset mid-transaction: abort to IDLE immediately; no response is issued; mem_req drops asynchronously.
- The non-owner's rsp_valid is always 0. Response data/err outputs hold their value between pulses.

Optional Feature:
MEM_ARB_ROUND_ROBIN_EN
- Defined: on simultaneous requests, the requester not granted last wins (last_grant register, reset FETCH, so data wins the first tie). The streak counter and MAX_DATA_STREAK are not implemented.
- Undefined: fixed data priority with the streak limit, as above.

Decomposition:
- Package mem_arb_pkg:
  - state enum (IDLE, ISSUE, WAIT, RESP)
  - requester-ID encoding (FETCH=0, DATA=1)
  - localparam for the all-ones fetch strobe
- One sub-module, mem_arb_select:
  - Inputs: both valids and the grant-enable.
  - Outputs: winner plus the streak or last_grant state.
  - Contains the ifdef, so the main FSM is feature-agnostic.

Test Plan:
1. Fetch only, i_addr=0x100, gnt immediate, rvalid 1 cycle later with 0xDEADBEEF -> mem_wstrb=0xF, mem_we=0; i_rsp_valid exactly 3 cycles after accept; i_rdata=0xDEADBEEF, i_rsp_err=0.
2. Both valid continuously, default build, MAX_DATA_STREAK=4 -> grant order D,D,D,D,I,D,D,D,D,I; i_rsp_valid never coincides with d_rsp_valid.
3. Data write addr=0x200, wdata=0x12345678, wstrb=0x3, gnt withheld 5 cycles -> mem fields stable for all 6 mem_req cycles; d_rsp_valid with d_rdata=0, err=0.
4. TIMEOUT=8, no rvalid -> d_rsp_err=1 after 8 WAIT cycles, d_rdata=0; a late rvalid 2 cycles later produces no response.
5. rst asserted in WAIT -> mem_req, rsp_valid and ready go to 0 without waiting for a clock edge; the next request after reset completes normally.
6. MEM_ARB_ROUND_ROBIN_EN defined, both valid continuously -> strict alternation D,I,D,I.
